// File: rtl/conv1d_mac_engine.sv
// One-output-pixel 1-D convolution engine behind a CPU custom-instruction port.
// Optional signed accumulator bias is enabled with `define CONV1D_MAC_BIAS_EN.
module conv1d_mac_engine #(
    parameter int DATA_W         = 8,
    parameter int ACC_W          = 32,
    parameter int KERNEL_LENGTH  = 8,
    parameter int MAX_CHANNELS   = 128,
    parameter int MACS_PER_CYCLE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [6:0]       cmd,
    input  logic [31:0]      inp0,
    input  logic [31:0]      inp1,
    output logic [ACC_W-1:0] ret,
    output logic             rsp_valid,
    output logic             busy
);
    localparam int ENTRIES = KERNEL_LENGTH * MAX_CHANNELS;
    localparam int ADDR_W  = $clog2(ENTRIES);
    localparam int IDX_W   = ADDR_W + 2;
    localparam int KX_W    = (KERNEL_LENGTH > 1) ? $clog2(KERNEL_LENGTH) : 1;
    localparam int DEPTH_W = $clog2(MAX_CHANNELS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] input_mem  [ENTRIES];
    logic [DATA_W-1:0] weight_mem [ENTRIES];

    logic [31:0]      input_offset;
    logic [31:0]      depth;
    logic [KX_W-1:0]  start_x;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] psum;
    logic [IDX_W-1:0] base;
    logic             finished;
    logic             err;
`ifdef CONV1D_MAC_BIAS_EN
    logic [31:0]      bias;
`endif

    logic [IDX_W-1:0] n_total, shift, idx, iaddr;
    logic [ACC_W-1:0] lane_sum, off_ext;
    logic signed [ACC_W-1:0] w_ext, x_ext;
    logic depth_ok, addr_ok, running, last_beat, start_ok;

    assign running   = (state_q != IDLE);
    assign depth_ok  = (depth != 32'd0) && (depth <= 32'(MAX_CHANNELS));
    assign addr_ok   = (inp0 < 32'(ENTRIES));
    assign n_total   = IDX_W'(KERNEL_LENGTH) * IDX_W'(depth[DEPTH_W-1:0]);
    assign shift     = IDX_W'(start_x) * IDX_W'(depth[DEPTH_W-1:0]);
    assign last_beat = (base + IDX_W'(MACS_PER_CYCLE)) >= n_total;
    assign off_ext   = ACC_W'($signed(input_offset));
    assign start_ok  = cmd_valid && (cmd == 7'd6) && !running && depth_ok;

    // One beat of lanes; the input address wraps around the ring of N entries
    // so start_x rotates which frame lines up with tap 0.
    always_comb begin
        lane_sum = '0;
        idx      = '0;
        iaddr    = '0;
        w_ext    = '0;
        x_ext    = '0;
        for (int l = 0; l < MACS_PER_CYCLE; l++) begin
            idx = base + IDX_W'(l);
            if (idx < n_total) begin
                iaddr = idx + shift;
                if (iaddr >= n_total) begin
                    iaddr = iaddr - n_total;
                end
                w_ext    = ACC_W'($signed(weight_mem[idx[ADDR_W-1:0]]));
                x_ext    = ACC_W'($signed(input_mem[iaddr[ADDR_W-1:0]]));
                lane_sum = lane_sum + ACC_W'(w_ext * (x_ext + $signed(off_ext)));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (last_beat) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cmd_valid && (cmd == 7'd0)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffers have no reset; writes only land while idle and in range.
    always_ff @(posedge clk) begin
        if (cmd_valid && !running && addr_ok) begin
            if (cmd == 7'd1) input_mem[inp0[ADDR_W-1:0]] <= inp1[DATA_W-1:0];
            if (cmd == 7'd2) weight_mem[inp0[ADDR_W-1:0]] <= inp1[DATA_W-1:0];
        end
    end

    // Job datapath first, then command handling so a clear overrides the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret          <= '0;
            rsp_valid    <= 1'b0;
            busy         <= 1'b0;
            acc          <= '0;
            psum         <= '0;
            base         <= '0;
            finished     <= 1'b1;
            err          <= 1'b0;
            input_offset <= '0;
            depth        <= '0;
            start_x      <= '0;
`ifdef CONV1D_MAC_BIAS_EN
            bias         <= '0;
`endif
        end else begin
            rsp_valid <= cmd_valid;
            if (state_q == RUN) begin
                psum <= lane_sum;
                acc  <= acc + psum;
                base <= base + IDX_W'(MACS_PER_CYCLE);
            end else if (state_q == DRAIN) begin
                acc      <= acc + psum;
                finished <= 1'b1;
                busy     <= 1'b0;
            end
            if (cmd_valid) begin
                ret <= '0;
                case (cmd)
                    7'd0: begin
                        acc      <= '0;
                        err      <= 1'b0;
                        finished <= 1'b1;
                        busy     <= 1'b0;
                    end
                    7'd1, 7'd2: if (running || !addr_ok) err <= 1'b1;
                    7'd3: if (running) err <= 1'b1; else input_offset <= inp1;
                    7'd4: if (running) err <= 1'b1; else depth <= inp1;
                    7'd5: if (running) err <= 1'b1;
                          else start_x <= KX_W'(inp1 % 32'(KERNEL_LENGTH));
                    7'd6: begin
                        if (!start_ok) begin
                            err <= 1'b1;
                        end else begin
`ifdef CONV1D_MAC_BIAS_EN
                            acc <= ACC_W'($signed(bias));
`else
                            acc <= '0;
`endif
                            psum     <= '0;
                            base     <= '0;
                            finished <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                    7'd7: ret <= acc;
                    7'd8: ret <= ACC_W'({err, busy, finished});
`ifdef CONV1D_MAC_BIAS_EN
                    7'd10: bias <= inp1;
`endif
                    default: ret <= '0;
                endcase
            end
        end
    end
endmodule
